// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store adapter: funct3 size codes,
// FSM state encoding and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  // Unsupported size codes, plus unsigned sizes on a store.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] low);
    case (funct3)
      F3_H, F3_HU: return low[0];
      F3_W:        return |low;
      default:     return 1'b0;
    endcase
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [1:0] align_low(input logic [2:0] funct3, input logic [1:0] low);
    case (funct3)
      F3_H, F3_HU: return {low[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return low;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane unit: extracts and extends load data from a
// memory word, and builds the merged word for sub-word stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    byte_sel  = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel  = addr[1] ? word[31:16] : word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Replace the addressed lane(s) of the current word with store data.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (addr)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// RV32 load/store adapter in front of a word-addressed memory with
// async read / sync write. Sub-word stores use read-modify-write.
// Build option LSU_MISALIGN_CHECK_EN: when defined, misaligned H/W
// accesses are rejected with rsp_err; otherwise low bits are cleared.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state, next_state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged_val;
  logic                  req_err;
  logic [1:0]            low_bits;
  logic                  write_en;
  logic                  unused_addr_hi;

  // Byte-address bits above the memory depth are ignored (address wrap).
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_err  = is_illegal(req_we, req_funct3) | is_misaligned(req_funct3, req_addr[1:0]);
  assign low_bits = req_addr[1:0];
`else
  assign req_err  = is_illegal(req_we, req_funct3);
  assign low_bits = align_low(req_funct3, req_addr[1:0]);
`endif

  assign mem_addr = addr_q[ADDR_WIDTH+1:2];
  // Gated by rst_n so an asserted reset suppresses the pending write at
  // the very edge it is sampled; an interrupted SB/SH leaves memory intact.
  assign mem_write = write_en & rst_n;

  lsu_byte_lane u_lane (
    .funct3    (funct3_q),
    .addr      (addr_q[1:0]),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_val),
    .merged    (merged_val)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and memory-side control.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    write_en   = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          next_state = RESP;
        end else if (funct3_q == F3_W) begin
          write_en   = 1'b1;
          mem_wdata  = wdata_q;
          next_state = RESP;
        end else begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        write_en   = 1'b1;
        mem_wdata  = merged_q;
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, load result and merged-word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merged_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (next_state == RESP);
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_q    <= {req_addr[ADDR_WIDTH+1:2], low_bits};
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
          end
        end
        ACCESS: begin
          if (!we_q) rsp_rdata <= load_val;
          else       merged_q  <= merged_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
Load/store adapter that sits directly upstream of the word-addressed data memory (async read, sync write, 32-bit words).
- Accepts RV32 load/store requests carrying byte addresses and funct3 sizes.
- Does read-modify-write for SB/SH.
- Extracts and sign/zero-extends LB/LH/LBU/LHU data.
- Returns one response pulse per request to the datapath.

Parameters:
DATA_WIDTH, 32, word width; fixed at 32 for RV32 byte-lane logic.
ADDR_WIDTH, 5, memory word-address width (memory depth 2**ADDR_WIDTH words).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  adapter idle and able to accept.
req_we  input  1  1=store, 0=load.
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  load result (0 for stores/errors).
rsp_err  output  1  misaligned or illegal funct3; qualified by rsp_valid.
mem_write  output  1  to memory write enable.
mem_addr  output  ADDR_WIDTH  to memory word address.
mem_wdata  output  32  to memory write data.
mem_rdata  input  32  from memory, combinational read of mem_addr.

Behaviour:
Reset values: state IDLE; all request registers 0; rsp_valid 0; rsp_rdata 0; rsp_err 0. Combinational outputs follow from these: req_ready 1, mem_write 0, mem_addr 0, mem_wdata 0.

- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
  - Illegal funct3 (011, 110, 111; and 100/101 with we=1) -> RESP with err=1.
  - Misaligned (H with addr[0]≠0; W with addr[1:0]≠0) -> RESP with err=1.
  - Otherwise -> ACCESS.
- ACCESS: mem_addr = latched addr[ADDR_WIDTH+1:2]; higher byte-address bits are ignored, so addresses wrap modulo the memory size.
  - Load: extract byte/half at addr[1:0] from mem_rdata; sign-extend (B/H) or zero-extend (BU/HU); register into rsp_rdata -> RESP.
  - SW: mem_write=1, mem_wdata=wdata -> RESP.
  - SB/SH: register merged word (mem_rdata with the addressed lane(s) replaced by wdata[7:0]/[15:0]) -> WRITE.
- WRITE: mem_write=1, mem_wdata=merged word, mem_addr unchanged -> RESP.
- RESP: rsp_valid=1 for exactly one cycle; req_ready=0 -> IDLE.
- mem_write is 0 in every state except ACCESS (SW only) and WRITE.
- Latency from the acceptance edge to rsp_valid: loads and SW 2 cycles; SB/SH 3 cycles; errors 1 cycle.
- req_ready=0 outside IDLE. A req_valid there is ignored and must be held by the requester.
- The next request is accepted in the cycle after RESP, giving a back-to-back throughput of one request per 3 (load/SW) or 4 (SB/SH) cycles.
- rsp_rdata/rsp_err hold their last value after rsp_valid drops and are cleared on acceptance of a new request.
- Reset mid-operation: next edge forces IDLE and mem_write 0. An interrupted SB/SH never writes, so memory is left unmodified.
- The merged word is taken from the same ACCESS-cycle read; no other memory writer exists, so no hazard.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misaligned H/W accesses are rejected with rsp_err=1 and no memory access, as above.
- Undefined: no misalignment detection. Low address bits below the access size are forced to 0 (H: addr[0], W: addr[1:0]) and the access proceeds normally with rsp_err=0. Illegal funct3 still errors.

Decomposition:
Package lsu_pkg:
- funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- State enum IDLE/ACCESS/WRITE/RESP.
- Function for misaligned detection.

Sub-module lsu_byte_lane: purely combinational.
- Inputs: funct3, addr[1:0], word, wdata.
- Outputs: extracted load value, merged store word.
- Instantiated once, in ACCESS.

Test Plan:
1. Preload word 3 = 0x80FF_7F01. LB addr 0x0D -> rsp_rdata 0x0000_007F; LB 0x0E -> 0xFFFF_FFFF; LBU 0x0F -> 0x0000_0080; rsp_valid 2 cycles after acceptance, rsp_err 0.
2. Word 3 = 0x1122_3344. SB addr 0x0E, wdata 0xAB -> mem_write pulses exactly once, 2 cycles after acceptance; word 3 = 0x11AB_3344; rsp_valid 3 cycles after acceptance.
3. SH addr 0x12, wdata 0xBEEF onto 0x0000_0000 -> word 4 = 0xBEEF_0000. Then LH 0x12 -> 0xFFFF_BEEF; LHU 0x12 -> 0x0000_BEEF.
4. With LSU_MISALIGN_CHECK_EN: SW addr 0x05 -> rsp_err 1 one cycle after acceptance, mem_write never asserted. Without it: word 1 written with wdata, rsp_err 0.
5. funct3=011 load -> rsp_err 1, rsp_rdata 0. SW addr 0x84 -> wraps to word 1.
6. Assert rst_n=0 during WRITE of SB -> memory unchanged, req_ready=1 and rsp_valid=0 the cycle after reset release.
